// File: rtl/usb_rx.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx
// Purpose  : Full-speed style USB packet receiver. Synchronizes D+/D-,
//            NRZI-decodes one bit per clock, removes bit stuffing, checks
//            SYNC/PID/EOP framing and streams DATA payload bytes (minus the
//            trailing CRC16) into the endpoint packet buffer.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dplus_in,
  input  logic       dminus_in,
  input  logic [6:0] buffer_occupancy,
  output logic [7:0] rx_packet_data,
  output logic       store_rx_packet_data,
  output logic       flush,
  output logic       rx_error,
  output logic       rx_transfer_active,
  output logic       rx_data_ready,
  output logic [3:0] rx_packet
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PID     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_EOP     = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERR     = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] dp_sync_q, dp_sync_d, dm_sync_q, dm_sync_d;
  logic       ref_j_q, ref_j_d;         // last J/K level seen (1 = J)
  logic [2:0] ones_q, ones_d;           // run of consecutive decoded 1s
  logic [2:0] bit_cnt_q, bit_cnt_d;     // bit position inside current byte
  logic [6:0] shift_q, shift_d;         // first seven bits of current byte
  logic [1:0] byte_cnt_q, byte_cnt_d;   // payload bytes, saturates at 3
  logic [3:0] pid_q, pid_d;             // PID of the packet in progress
  logic [7:0] hold0_q, hold0_d;         // older held-back DATA byte
  logic [7:0] hold1_q, hold1_d;         // newer held-back DATA byte
  logic       se0_seen_q, se0_seen_d;   // ERR recovery: SE0 already observed
  logic [7:0] data_q, data_d;
  logic       store_q, store_d;
  logic       flush_q, flush_d;
  logic       error_q, error_d;
  logic       active_q, active_d;
  logic       ready_q, ready_d;
  logic [3:0] packet_q, packet_d;

  logic       line_j, line_k, line_se0;
  logic       nrzi_bit, stuff_slot, pid_valid;
  logic       is_token, is_data;
  logic       go_err, go_err_se0;
  logic [7:0] new_byte;

  // Both-high is folded into SE0 since it is neither J nor K.
  assign line_j     = dp_sync_q[1] & ~dm_sync_q[1];
  assign line_k     = ~dp_sync_q[1] & dm_sync_q[1];
  assign line_se0   = ~(line_j | line_k);
  assign nrzi_bit   = (line_j == ref_j_q);
  assign stuff_slot = (ones_q == 3'd6);
  assign new_byte   = {nrzi_bit, shift_q};
  assign is_token   = (pid_q[1:0] == 2'b01);
  assign is_data    = (pid_q[1:0] == 2'b11);

  // PID byte is legal when the code is known and the high nibble is its complement.
  always_comb begin
    case (new_byte[3:0])
      4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110:
        pid_valid = (new_byte[7:4] == ~new_byte[3:0]);
      default:
        pid_valid = 1'b0;
    endcase
  end

  // Next-state logic for the synchronizer, decoder and packet FSM.
  always_comb begin
    state_d    = state_q;
    dp_sync_d  = {dp_sync_q[0], dplus_in};
    dm_sync_d  = {dm_sync_q[0], dminus_in};
    ref_j_d    = ref_j_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    pid_d      = pid_q;
    hold0_d    = hold0_q;
    hold1_d    = hold1_q;
    se0_seen_d = se0_seen_q;
    data_d     = data_q;
    store_d    = 1'b0;
    flush_d    = 1'b0;
    error_d    = error_q;
    active_d   = active_q;
    ready_d    = 1'b0;
    packet_d   = packet_q;
    go_err     = 1'b0;
    go_err_se0 = 1'b0;

    if (line_j || line_k) ref_j_d = line_j;

    case (state_q)
      ST_IDLE: begin
        // The first K is itself the first SYNC bit (a 0).
        if (line_k) begin
          state_d   = ST_SYNC;
          active_d  = 1'b1;
          error_d   = 1'b0;
          bit_cnt_d = 3'd1;
          ones_d    = 3'd0;
        end
      end
      ST_SYNC, ST_PID, ST_PAYLOAD: begin
        if (line_se0) begin
          go_err_se0 = 1'b1;
          if (state_q != ST_PAYLOAD) go_err = 1'b1;
          else if ((bit_cnt_q != 3'd0) ||
                   (is_token && (byte_cnt_q != 2'd2)) ||
                   (is_data && (byte_cnt_q < 2'd2))) go_err = 1'b1;
          else state_d = ST_EOP;
        end else if (stuff_slot) begin
          if (nrzi_bit) go_err = 1'b1;
          else          ones_d = 3'd0;
        end else begin
          ones_d    = nrzi_bit ? ones_q + 3'd1 : 3'd0;
          bit_cnt_d = bit_cnt_q + 3'd1;
          shift_d   = new_byte[7:1];
          if (state_q == ST_SYNC) begin
            if (nrzi_bit != (bit_cnt_q == 3'd7)) go_err  = 1'b1;
            else if (bit_cnt_q == 3'd7)          state_d = ST_PID;
          end else if (bit_cnt_q == 3'd7) begin
            if (state_q == ST_PID) begin
              if (pid_valid) begin
                pid_d      = new_byte[3:0];
                byte_cnt_d = 2'd0;
                state_d    = ST_PAYLOAD;
                if ((new_byte[1:0] == 2'b11) && (buffer_occupancy != 7'd0)) flush_d = 1'b1;
              end else begin
                go_err = 1'b1;
              end
            end else begin
              byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
              // DATA bytes trail two behind so the CRC16 never reaches the buffer.
              if (is_data) begin
                if (byte_cnt_q >= 2'd2) begin
                  if (buffer_occupancy == 7'd64) go_err = 1'b1;
                  else begin
                    store_d = 1'b1;
                    data_d  = hold0_q;
                  end
                end
                hold0_d = hold1_q;
                hold1_d = new_byte;
              end
            end
          end
        end
      end
      ST_EOP: begin
        if (line_j) begin
          state_d  = ST_DONE;
          ready_d  = 1'b1;
          packet_d = pid_q;
          active_d = 1'b0;
        end else if (line_k) begin
          go_err = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR: begin
        // Ignore everything until an SE0 followed by J.
        if (line_se0) se0_seen_d = 1'b1;
        else if (line_j && se0_seen_q) begin
          state_d    = ST_IDLE;
          active_d   = 1'b0;
          se0_seen_d = 1'b0;
        end else if (line_k) se0_seen_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_err) begin
      state_d    = ST_ERR;
      error_d    = 1'b1;
      se0_seen_d = go_err_se0;
    end
  end

  // State and output registers with synchronous reset; line idles at J.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= ST_IDLE;
      dp_sync_q  <= 2'b11;
      dm_sync_q  <= 2'b00;
      ref_j_q    <= 1'b1;
      ones_q     <= 3'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_cnt_q <= 2'd0;
      pid_q      <= 4'd0;
      hold0_q    <= 8'd0;
      hold1_q    <= 8'd0;
      se0_seen_q <= 1'b0;
      data_q     <= 8'd0;
      store_q    <= 1'b0;
      flush_q    <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
      ready_q    <= 1'b0;
      packet_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      dp_sync_q  <= dp_sync_d;
      dm_sync_q  <= dm_sync_d;
      ref_j_q    <= ref_j_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      pid_q      <= pid_d;
      hold0_q    <= hold0_d;
      hold1_q    <= hold1_d;
      se0_seen_q <= se0_seen_d;
      data_q     <= data_d;
      store_q    <= store_d;
      flush_q    <= flush_d;
      error_q    <= error_d;
      active_q   <= active_d;
      ready_q    <= ready_d;
      packet_q   <= packet_d;
    end
  end

  assign rx_packet_data       = data_q;
  assign store_rx_packet_data = store_q;
  assign flush                = flush_q;
  assign rx_error             = error_q;
  assign rx_transfer_active   = active_q;
  assign rx_data_ready        = ready_q;
  assign rx_packet            = packet_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx
// Purpose  : Self-checking bench for usb_rx. Packets are described as byte
//            lists, encoded onto the line (stuffing + NRZI) and the expected
//            stores, flush, ready, PID and error are derived from the packet
//            description.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx;
  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       dplus_in = 1'b1;
  logic       dminus_in = 1'b0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data, flush, rx_error, rx_transfer_active, rx_data_ready;
  logic [3:0] rx_packet;

  usb_rx dut (
    .clk(clk), .n_rst(n_rst), .dplus_in(dplus_in), .dminus_in(dminus_in),
    .buffer_occupancy(buffer_occupancy), .rx_packet_data(rx_packet_data),
    .store_rx_packet_data(store_rx_packet_data), .flush(flush), .rx_error(rx_error),
    .rx_transfer_active(rx_transfer_active), .rx_data_ready(rx_data_ready),
    .rx_packet(rx_packet)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         obs_cyc[$];
  logic [7:0] obs_dat[$];
  int         obs_flush[$];
  int         obs_ready[$];
  int         act_fall = -1;
  int         saw_active = 0;
  int         b2b = 0;
  logic       prev_store = 1'b0, prev_active = 1'b0;
  always @(negedge clk) begin
    if (store_rx_packet_data) begin
      obs_cyc.push_back(cyc);
      obs_dat.push_back(rx_packet_data);
      if (prev_store) b2b++;
    end
    if (flush) obs_flush.push_back(cyc);
    if (rx_data_ready) obs_ready.push_back(cyc);
    if (rx_transfer_active) saw_active = 1;
    if (prev_active && !rx_transfer_active) act_fall = cyc;
    prev_store  = store_rx_packet_data;
    prev_active = rx_transfer_active;
  end

  task automatic clear_obs();
    obs_cyc.delete(); obs_dat.delete(); obs_flush.delete(); obs_ready.delete();
    act_fall = -1; saw_active = 0; b2b = 0;
  endtask

  // Packet description and line encoding.
  logic [7:0] sync_byte, pid_byte;
  logic [7:0] pay[$];
  int         n_extra, se0_len;
  logic       se0_hi;
  logic [1:0] lvl[$];
  int         bend[$];     // line index of the last data bit of each byte
  int         ones;
  logic       cur_j;
  int         start_cyc, j_cyc;
  logic [3:0] exp_pid = 4'd0;

  task automatic push_bit(input logic b, output int idx);
    if (!b) cur_j = ~cur_j;
    lvl.push_back(cur_j ? 2'b10 : 2'b01);
    idx  = lvl.size() - 1;
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      cur_j = ~cur_j;
      lvl.push_back(cur_j ? 2'b10 : 2'b01);
      ones = 0;
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    int idx;
    idx = 0;
    for (int b = 0; b < 8; b++) push_bit(v[b], idx);
    bend.push_back(idx);
  endtask

  task automatic encode();
    int idx;
    logic [7:0] xb;
    lvl.delete(); bend.delete(); ones = 0; cur_j = 1'b1;
    push_byte(sync_byte);
    push_byte(pid_byte);
    foreach (pay[i]) push_byte(pay[i]);
    xb = 8'($urandom);
    for (int b = 0; b < n_extra; b++) push_bit(xb[b], idx);
  endtask

  task automatic drive_levels(input int count);
    logic [1:0] l;
    for (int k = 0; k < count; k++) begin
      @(posedge clk); #1;
      if (k == 0) start_cyc = cyc;
      l = lvl[k];
      dplus_in = l[1]; dminus_in = l[0];
    end
  endtask

  task automatic send();
    encode();
    drive_levels(lvl.size());
    for (int k = 0; k < se0_len; k++) begin
      @(posedge clk); #1;
      dplus_in = se0_hi; dminus_in = se0_hi;
    end
    @(posedge clk); #1;
    dplus_in = 1'b1; dminus_in = 1'b0; j_cyc = cyc;
    repeat (10) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic pid_legal(input logic [7:0] p);
    logic [3:0] lo;
    lo = p[3:0];
    return (p[7:4] == ~lo) && (lo inside {4'h1, 4'h9, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE});
  endfunction

  task automatic new_pkt(input logic [7:0] pid, input int occ);
    sync_byte = 8'h80; pid_byte = pid; pay.delete(); n_extra = 0;
    buffer_occupancy = 7'(occ);
    se0_len = $urandom_range(1, 3);
    se0_hi  = ($urandom_range(0, 3) == 0);
  endtask

  // Send the described packet and compare against the rule-derived outcome.
  task automatic run_packet(input string name);
    logic [7:0] exp_dat[$];
    int         exp_cyc[$];
    logic       err;
    int         exp_flush, n;
    logic [3:0] lo;
    clear_obs();
    send();
    lo = pid_byte[3:0]; n = pay.size(); err = 1'b0; exp_flush = 0;
    if (sync_byte != 8'h80 || !pid_legal(pid_byte)) err = 1'b1;
    else begin
      if (lo == 4'h3 || lo == 4'hB) begin
        if (buffer_occupancy != 7'd0) exp_flush = 1;
        if (buffer_occupancy == 7'd64 && n >= 3) err = 1'b1;
        else for (int i = 0; i + 2 < n; i++) begin
          exp_dat.push_back(pay[i]);
          exp_cyc.push_back(start_cyc + bend[i + 4] + 3);
        end
        if (n < 2) err = 1'b1;
      end
      if ((lo == 4'h1 || lo == 4'h9) && n != 2) err = 1'b1;
      if (n_extra != 0) err = 1'b1;
    end
    if (!err) exp_pid = lo;

    check({name, " store count"}, obs_dat.size(), exp_dat.size());
    for (int i = 0; i < exp_dat.size() && i < obs_dat.size(); i++) begin
      check({name, " store data"}, 32'(obs_dat[i]), 32'(exp_dat[i]));
      check({name, " store cycle"}, obs_cyc[i], exp_cyc[i]);
    end
    check({name, " flush count"}, obs_flush.size(), exp_flush);
    if (exp_flush == 1 && obs_flush.size() > 0)
      check({name, " flush cycle"}, obs_flush[0], start_cyc + bend[1] + 3);
    check({name, " ready count"}, obs_ready.size(), err ? 0 : 1);
    if (!err && obs_ready.size() > 0)
      check({name, " ready cycle"}, obs_ready[0], j_cyc + 3);
    check({name, " active seen"}, saw_active, 1);
    check({name, " active fall cycle"}, act_fall, j_cyc + 3);
    check({name, " rx_error"}, 32'(rx_error), 32'(err));
    check({name, " rx_packet"}, 32'(rx_packet), 32'(exp_pid));
    check({name, " active idle"}, 32'(rx_transfer_active), 0);
    check({name, " back-to-back stores"}, b2b, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] lo;
    int         occ_sel, kind, n;
    // Reset with the line idling at J.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rx_packet_data", 32'(rx_packet_data), 0);
    check("reset store", 32'(store_rx_packet_data), 0);
    check("reset flush", 32'(flush), 0);
    check("reset rx_error", 32'(rx_error), 0);
    check("reset active", 32'(rx_transfer_active), 0);
    check("reset ready", 32'(rx_data_ready), 0);
    check("reset rx_packet", 32'(rx_packet), 0);
    @(posedge clk); #1 n_rst = 1'b0;
    clear_obs();
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("idle active seen", saw_active, 0);
    check("idle store count", obs_dat.size(), 0);

    new_pkt(8'hD2, 0);
    run_packet("ack");

    new_pkt(8'hC3, 0);
    pay.push_back(8'h00); pay.push_back(8'h01); pay.push_back(8'hAB); pay.push_back(8'hCD);
    run_packet("data0");

    new_pkt(8'h4B, 5);
    pay.push_back(8'hFF); pay.push_back(8'h12); pay.push_back(8'h34);
    run_packet("data1 stuffed");

    new_pkt(8'hF1, 0);
    run_packet("bad pid");
    new_pkt(8'hD2, 0);
    run_packet("ack after error");

    new_pkt(8'hE1, 0);
    pay.push_back(8'h3A); pay.push_back(8'hC5);
    run_packet("out token");
    new_pkt(8'hE1, 0);
    pay.push_back(8'h3A); pay.push_back(8'hC5); n_extra = 3;
    run_packet("out misaligned");

    new_pkt(8'hC3, 64);
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom));
    run_packet("data overflow");

    // Reset in the middle of a DATA packet.
    new_pkt(8'hC3, 5);
    for (int i = 0; i < 6; i++) pay.push_back(8'($urandom));
    encode();
    drive_levels(36);
    @(posedge clk); #1;
    n_rst = 1'b1; dplus_in = 1'b1; dminus_in = 1'b0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b0;
    exp_pid = 4'd0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("abort store count", obs_dat.size(), 0);
    check("abort ready count", obs_ready.size(), 0);
    check("abort flush count", obs_flush.size(), 0);
    check("abort active", 32'(rx_transfer_active), 0);
    check("abort rx_error", 32'(rx_error), 0);
    check("abort rx_packet", 32'(rx_packet), 0);

    for (int p = 0; p < 40; p++) begin
      occ_sel = $urandom_range(0, 3);
      kind    = $urandom_range(0, 5);
      lo      = 4'h3;
      case (kind)
        0: begin
          case ($urandom_range(0, 2))
            0: lo = 4'h2;
            1: lo = 4'hA;
            default: lo = 4'hE;
          endcase
          new_pkt({~lo, lo}, 0);
        end
        1: begin
          lo = ($urandom_range(0, 1) == 0) ? 4'h1 : 4'h9;
          new_pkt({~lo, lo}, 0);
          n = ($urandom_range(0, 9) < 7) ? 2 : $urandom_range(0, 3);
          for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        end
        2, 3: begin
          lo = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'hB;
          new_pkt({~lo, lo}, (occ_sel == 0) ? 0 : (occ_sel == 1) ? 5 : (occ_sel == 2) ? 63 : 64);
          n = $urandom_range(0, 10);
          for (int i = 0; i < n; i++)
            pay.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
        end
        4: begin
          new_pkt(8'h00, 0);
          do pid_byte = 8'($urandom); while (pid_legal(pid_byte));
          n = $urandom_range(0, 3);
          for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        end
        default: begin
          lo = ($urandom_range(0, 1) == 0) ? 4'h3 : 4'h1;
          new_pkt({~lo, lo}, 5);
          n = $urandom_range(2, 5);
          for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
          if ($urandom_range(0, 1) == 0) sync_byte = 8'h84;
          else n_extra = $urandom_range(1, 7);
        end
      endcase
      run_packet($sformatf("rand%0d", p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_rx.md
# usb_rx

USB full-speed style packet receiver for the USB endpoint. It decodes the NRZI-encoded D+/D- line pair at one bit per clock. It removes bit stuffing, detects SYNC, PID and EOP, and streams DATA payload bytes into the shared 64-byte packet buffer. It reports the received PID, completion and error status to the endpoint control logic.

## Interface
- No parameters. The buffer depth is fixed at 64 bytes.
- clk  in  1  system clock; the line is sampled once per rising edge (1 bit per cycle)
- n_rst  in  1  reset, synchronous, active-high: asserted = 1 resets on the next rising clk edge
- dplus_in  in  1  D+ line; idle (J) is D+ = 1
- dminus_in  in  1  D- line; idle (J) is D- = 0
- buffer_occupancy  in  7  current number of bytes in the packet buffer (0..64)
- rx_packet_data  out  8  payload byte presented with store_rx_packet_data
- store_rx_packet_data  out  1  one-cycle pulse: write rx_packet_data into the buffer
- flush  out  1  one-cycle pulse: clear the buffer before a new DATA payload
- rx_error  out  1  sticky error flag for the current/last packet
- rx_transfer_active  out  1  high while a packet is being received
- rx_data_ready  out  1  one-cycle pulse: packet completed without error
- rx_packet  out  4  PID of the last completed packet

## Operation
- Line states:
  - J: D+ = 1, D- = 0.
  - K: D+ = 0, D- = 1.
  - SE0: both lines 0.
  - Both lines 1 is treated as SE0.
- dplus_in/dminus_in pass through a 2-flop synchronizer before decoding.
- NRZI decoding:
  - A change of J/K state from the previous cycle decodes as bit 0.
  - No change decodes as bit 1.
  - The reference state after reset/idle is J.
- Bit unstuffing: after six consecutive decoded 1s, the next bit is discarded if it is 0. If that bit is 1, it is a stuff error.
- Bits are assembled LSB-first into bytes.
- FSM states: IDLE, SYNC, PID, PAYLOAD, EOP, DONE, ERR.
  - IDLE -> SYNC on the first K.
  - SYNC requires the decoded bit sequence 0,0,0,0,0,0,0,1 (KJKJKJKK). Any mismatch -> ERR.
  - PID byte: the low nibble is the PID and the high nibble must equal its complement.
    - Valid PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010, STALL 1110.
    - A complement mismatch or any other code -> ERR.
  - PAYLOAD:
    - Token (OUT/IN): exactly 2 bytes (address/endpoint/CRC5) are received and discarded.
    - DATA0/DATA1: bytes are held back 2 deep. A byte is stored only once two further bytes have arrived, so the final 2 bytes (CRC16) are never stored. CRC is not checked.
    - Handshake: no payload.
  - EOP: SE0 on at least 1 cycle followed by J. A packet completes on the J sample.
  - EOP is an error (-> ERR) in any of these cases:
    - it is not byte-aligned;
    - it comes before the PID completes;
    - a token has a byte count other than 2;
    - a DATA packet has fewer than 2 bytes after the PID.
  - DATA byte overflow -> ERR: a store is due while buffer_occupancy = 64.
  - ERR ignores the line until EOP + J, then returns to IDLE.
- flush: one-cycle pulse on the cycle after a valid DATA0/DATA1 PID byte, only when buffer_occupancy != 0.
- rx_transfer_active:
  - Set on the cycle SYNC is entered.
  - Cleared on the cycle after EOP completes, or after ERR exits.
- On error-free completion:
  - rx_packet <= PID.
  - rx_data_ready pulses 1 cycle.
- On error:
  - rx_error <= 1 and rx_packet is unchanged.
  - rx_error clears when the next SYNC is entered.

## Timing
- Reset values of all outputs:
  - rx_packet_data = 0, rx_packet = 0.
  - store_rx_packet_data, flush, rx_error, rx_transfer_active, rx_data_ready = 0.
  - FSM = IDLE, NRZI reference = J.
- Decode latency: a bit's line state applied before edge N is decoded at edge N+2 (synchronizer).
- store_rx_packet_data is asserted 1 cycle after the last bit of the byte that releases the held byte. rx_packet_data is valid in the same cycle and holds until the next store.
- rx_data_ready and the rx_packet update occur 1 cycle after the J that ends EOP. rx_transfer_active falls in the same cycle.
- At most one store per 8 bit-times, so no back-to-back stores.
- n_rst mid-packet aborts with no store, flush or ready pulse.
- All outputs are registered.

## Test plan
- Reset with the lines at J -> all outputs 0; rx_transfer_active stays 0 while the line idles.
- ACK packet (SYNC, PID byte 0xD2, EOP) -> rx_packet = 0010, one rx_data_ready pulse, no store, no flush, rx_error = 0.
- DATA0 with buffer_occupancy = 0, payload 0x00, 0x01, CRC 0xAB, 0xCD -> exactly two stores (0x00 then 0x01), no flush, rx_packet = 0011, rx_data_ready pulse.
- DATA1 with buffer_occupancy = 5 -> flush pulses once after the PID; payload 0xFF with a stuffed 0 after six 1s -> stored byte 0xFF, rx_error = 0.
- PID byte 0xF1 (complement mismatch) -> rx_error = 1, no store, no rx_data_ready, rx_packet unchanged; the next valid SYNC clears rx_error.
- OUT token, 2 bytes, then EOP mid-byte on a following packet -> first: rx_packet = 0001 and ready; second: rx_error = 1 and rx_transfer_active falls after the EOP.
